// File: rtl/i2c_target_regs_pkg.sv
// Shared I2C definitions: target FSM states and bus field widths.
// The camera-side masters import this package as well.
package i2c_pkg;
   localparam int I2C_ADDR_W = 7;
   localparam int I2C_BYTE_W = 8;
   localparam int I2C_RW_BIT = 0;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_IGNORE
   } i2c_state_e;
endpackage

// File: rtl/i2c_target_regs_line_sync.sv
// Brings SCL/SDA into the clock_i2c domain and derives edge plus START/STOP events.
module i2c_line_sync (
   input  logic clock_i2c,
   input  logic camera_rstn,
   input  logic i2c_sclk,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_s,
   output logic start_det,
   output logic stop_det
);
   logic [1:0] scl_ff, sda_ff;
   logic       scl_h, sda_h, scl_s;

   // Reset to the idle-bus level so release from reset produces no spurious events.
   always_ff @(posedge clock_i2c or negedge camera_rstn) begin
      if (!camera_rstn) begin
         scl_ff <= 2'b11;
         sda_ff <= 2'b11;
         scl_h  <= 1'b1;
         sda_h  <= 1'b1;
      end else begin
         scl_ff <= {scl_ff[0], i2c_sclk};
         sda_ff <= {sda_ff[0], sda_in};
         scl_h  <= scl_ff[1];
         sda_h  <= sda_ff[1];
      end
   end

   assign scl_s     = scl_ff[1];
   assign sda_s     = sda_ff[1];
   assign scl_rise  = scl_s & ~scl_h;
   assign scl_fall  = ~scl_s & scl_h;
   assign start_det = scl_s & sda_h & ~sda_s;
   assign stop_det  = scl_s & ~sda_h & sda_s;
endmodule

// File: rtl/i2c_target_regs.sv
// I2C target mapping bus writes/reads onto a byte-wide register port with
// an auto-incrementing pointer; SDA is driven open-drain.
module i2c_target_regs import i2c_pkg::*; #(
   parameter logic [I2C_ADDR_W-1:0] DEV_ADDR = 7'h48
) (
   input  logic                  clock_i2c,
   input  logic                  camera_rstn,
   input  logic                  i2c_sclk,
   inout  wire                   i2c_sdat,
   output logic [I2C_BYTE_W-1:0] reg_addr,
   output logic [I2C_BYTE_W-1:0] reg_wdata,
   output logic                  reg_wr,
   output logic                  reg_rd,
   input  logic [I2C_BYTE_W-1:0] reg_rdata,
   output logic                  busy
);
   logic                  scl_rise, scl_fall, sda_s, start_det, stop_det;
   i2c_state_e            state;
   logic [3:0]            bit_cnt;
   logic [I2C_BYTE_W-1:0] rx_sr, tx_sr, rx_byte;
   logic                  sda_oe, rd_mode, rd_d, last_bit;

   i2c_line_sync u_sync (
      .clock_i2c   (clock_i2c),
      .camera_rstn (camera_rstn),
      .i2c_sclk    (i2c_sclk),
      .sda_in      (i2c_sdat),
      .scl_rise    (scl_rise),
      .scl_fall    (scl_fall),
      .sda_s       (sda_s),
      .start_det   (start_det),
      .stop_det    (stop_det)
   );

   assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;
   assign rx_byte  = {rx_sr[I2C_BYTE_W-2:0], sda_s};
   assign last_bit = (bit_cnt == 4'd7);

   always_ff @(posedge clock_i2c or negedge camera_rstn) begin
      if (!camera_rstn) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         sda_oe    <= 1'b0;
         rd_mode   <= 1'b0;
         rd_d      <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         reg_wr <= 1'b0;
         reg_rd <= 1'b0;
         rd_d   <= reg_rd;
         if (rd_d) tx_sr <= reg_rdata;
         if (start_det) begin
            state   <= ST_ADDR;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
         end else if (stop_det) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               ST_ADDR, ST_PTR, ST_WDATA: if (scl_rise) begin
                  rx_sr   <= rx_byte;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (last_bit && state == ST_ADDR) begin
                     if (rx_byte[I2C_BYTE_W-1:1] == DEV_ADDR) begin
                        busy    <= 1'b1;
                        rd_mode <= rx_byte[I2C_RW_BIT];
                        reg_rd  <= rx_byte[I2C_RW_BIT];
                        state   <= ST_ADDR_ACK;
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end else if (last_bit && state == ST_PTR) begin
                     reg_addr <= rx_byte;
                     state    <= ST_PTR_ACK;
                  end else if (last_bit) begin
                     reg_wdata <= rx_byte;
                     reg_wr    <= 1'b1;
                     state     <= ST_WDATA_ACK;
                  end
               end
               // First fall pulls SDA low for the ACK, second fall ends the ACK slot.
               ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe <= 1'b1;
                  end else begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= '0;
                     if (state == ST_ADDR_ACK && rd_mode) begin
                        sda_oe <= ~tx_sr[I2C_BYTE_W-1];
                        tx_sr  <= {tx_sr[I2C_BYTE_W-2:0], 1'b0};
                        state  <= ST_RDATA;
                     end else if (state == ST_ADDR_ACK) begin
                        state <= ST_PTR;
                     end else if (state == ST_PTR_ACK) begin
                        state <= ST_WDATA;
                     end else begin
                        reg_addr <= reg_addr + 8'd1;
                        state    <= ST_WDATA;
                     end
                  end
               end
               ST_RDATA: begin
                  if (scl_rise && bit_cnt != 4'd8) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     sda_oe <= 1'b0;
                     state  <= ST_RDATA_ACK;
                  end else if (scl_fall) begin
                     sda_oe <= ~tx_sr[I2C_BYTE_W-1];
                     tx_sr  <= {tx_sr[I2C_BYTE_W-2:0], 1'b0};
                  end
               end
               ST_RDATA_ACK: if (scl_rise) begin
                  if (!sda_s) begin
                     reg_addr <= reg_addr + 8'd1;
                     reg_rd   <= 1'b1;
                     bit_cnt  <= '0;
                     state    <= ST_RDATA;
                  end else begin
                     state <= ST_IGNORE;
                  end
               end
               ST_IDLE, ST_IGNORE: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) that answers the 7-bit device address `0x48`, the `0x90`/`0x91` address-byte pair on the wire, and maps bus transfers onto a byte-wide register port. It is the responder end of the SCLK/SDIN sequences our camera-side masters generate. We use it for FPGA-internal configuration registers and as a synthesizable camera model in simulation. It oversamples the bus on `clock_i2c` and drives `i2c_sdat` open-drain.

## Interface
- `DEV_ADDR`, default `7'h48`: 7-bit address this target acknowledges.
- `clock_i2c` in 1: oversampling clock; must be ≥16× the SCL frequency.
- `camera_rstn` in 1: asynchronous, active-low reset.
- `i2c_sclk` in 1: bus clock, driven by the master.
- `i2c_sdat` inout 1: bus data; this block drives only `0` or `z`.
- `reg_addr` out 8: register pointer.
- `reg_wdata` out 8: write data, valid with `reg_wr`.
- `reg_wr` out 1: one-cycle write strobe.
- `reg_rd` out 1: one-cycle read request at `reg_addr`.
- `reg_rdata` in 8: read data, sampled exactly 1 cycle after `reg_rd`.
- `busy` out 1: high from an address match until STOP or a new START.

## Operation
- `i2c_sclk` and `i2c_sdat` pass through 2-flop synchronizers plus a history flop, which yields rise/fall events.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high. Both take priority over bit events in the same cycle.
- Bits are sampled on the SCL rise event, MSB first. This block changes SDA only on the SCL fall event.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START in any state clears the bit counter, releases SDA and enters ADDR. This also covers repeated START.
- STOP in any state releases SDA, enters IDLE and discards any partial byte.
- ADDR, after 8 bits:
  - Address mismatch → IGNORE, with no ACK.
  - Match with R/W=0 → ADDR_ACK, then PTR.
  - Match with R/W=1 → ADDR_ACK, then RDATA. `reg_rd` pulses on the 8th rise.
- ACK timing: on the fall event after the 8th bit, pull SDA low. On the next fall event, release it.
- PTR: the byte loads `reg_addr`. It is ACKed, then the FSM goes to WDATA.
- WDATA: after the 8th bit, `reg_wdata` is updated and `reg_wr` pulses for 1 cycle. The byte is ACKed. `reg_addr` increments on the ACK-release fall.
- RDATA:
  - The TX shift register loads `reg_rdata` one cycle after `reg_rd`.
  - Bit 7 is driven on the fall that ends ADDR_ACK or RDATA_ACK; later bits are driven on successive falls.
  - A `1` bit releases SDA.
  - After 8 bits, SDA is released and the master's ACK is sampled on the 9th rise.
- RDATA_ACK:
  - Master ACK (SDA=0): `reg_addr` increments, `reg_rd` pulses, and the FSM returns to RDATA.
  - Master NACK: → IGNORE.
- `reg_addr` wraps `0xFF → 0x00`.
- IGNORE keeps SDA released and waits for START or STOP.

## Timing
- Reset values:
  - `i2c_sdat` = z.
  - `reg_addr` = 0, `reg_wdata` = 0.
  - `reg_wr` = 0, `reg_rd` = 0, `busy` = 0.
  - FSM in IDLE.
- Reset mid-transfer releases SDA asynchronously, within the reset assertion.
- Latency from a pin edge to the internal event is 3 `clock_i2c` cycles.
- SDA is driven 1 cycle after the fall event, i.e. 4 cycles after the SCL pin falls. This is well inside the SCL-low half-period at ≥16× oversampling.
- `reg_wr` and `reg_rd` are never asserted in the same cycle. At most one strobe occurs per byte.
- `busy` rises in the cycle the ADDR match is decided. It falls with STOP or START.

## Structure
- Package `i2c_pkg`: FSM state enum, `I2C_ADDR_W = 7`, `I2C_BYTE_W = 8`, and the R/W bit position. The masters share it.
- Sub-module `i2c_line_sync`: synchronizers, rise/fall detect and START/STOP detect. Outputs: `scl_rise`, `scl_fall`, `sda_s`, `start_det`, `stop_det`.
- Top level: FSM, bit counter (0–8), RX/TX shift registers, pointer and strobes.

## Test plan
- Master writes `0x90, 0x05, 0xA5, 0x3C`, STOP:
  - SDA is low on all four 9th clocks.
  - `reg_wr` fires with (`0x05`, `0xA5`), then (`0x06`, `0x3C`).
  - `busy` falls at STOP.
- Master writes `0x90, 0x10`, repeated START, `0x91`, reads 2 bytes (ACK, then NACK). The model returns `~reg_addr`:
  - Received bytes are `0xEF` then `0xEE`.
  - SDA is released after the NACK.
- Master sends `0x92`: SDA stays high at the 9th clock, with no strobes and `busy`=0.
- Master writes pointer `0xFF`, then 2 data bytes: writes go to `0xFF` then `0x00`.
- Master sends STOP after 5 bits of a WDATA byte: no `reg_wr`, FSM returns to IDLE.
- Reset is asserted during a read while this block drives a `0` bit: SDA goes to z immediately, and all outputs return to their reset values.
